seg_display_scanner: RTL and testbench
======================================

Name: seg_display_scanner

Overview:
- Consumer end of the `sign` display bus produced by the hood control FSM.
- Format of `sign`: {24-bit BCD time HHMMSS, 8-bit tag}.
- Time-multiplexes eight 7-segment digits, decodes the tag into a mode prefix, and blinks the field being edited in set states.
- Sits between the control block and the board's digit/segment pins.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- SCAN_HZ, 1000, digit-switch rate. Cycles per digit slot DIV = CLK_HZ/SCAN_HZ.
- BLINK_HZ, 2, blink rate. Phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.
- BLANK_CYC, 16, anti-ghost blank cycles at the start of each digit slot. Must be < DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sign  in  32  display word: [31:8] BCD HHMMSS, [7:0] tag
- state  in  7  current control-FSM state code
- an  out  8  digit enables, one-hot, active-high; an[7] is the leftmost digit
- seg  out  8  segments, active-high, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (rst=0, async): an=0, seg=0, digit index=0, slot/blink counters=0, blink phase=visible, shadow=0.
- Slot counter counts 0..DIV-1.
  - At DIV-1: digit index advances 0→1→…→7→0.
  - When the index wraps 7→0, `sign` and `state` are latched into shadow registers. All decode uses the shadow, so the display never tears within a frame.
- Within a slot:
  - Cycles 0..BLANK_CYC-1: an=0, seg=0.
  - Remaining cycles: an = one-hot(index), seg = decoded value. Both are registered, so outputs lag the index by 1 cycle.
- Digit map:
  - Digits 5..0 = sign[31:28]..sign[11:8] (H tens, H ones, M tens, M ones, S tens, S ones).
  - Digits 7..6 = tag prefix.
- Tag prefix:
  - 0x00 (now time): blank, blank.
  - 0x01 / 0x02 / 0x03 (work / switch / remind time): 'C', '1' / '2' / '3'.
  - Tag >= 0x04 (countdown): tag[7:4], tag[3:0] shown as BCD digits.
- Nibble decode: 0..9 → 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F. Nibble >9 → '-' (0x40). 'C' = 0x39.
- dp (seg[7]) is lit on digits 4 and 2 (HH.MM.SS separators) and off elsewhere.
- Shutdown: shadow state == 7'b0000000 → an=0 for the whole frame. Counters keep running.
- Blink:
  - Applies when shadow state[6:3] == 4'b1111 (set states).
  - Edited field: state[1:0]=01 → digits 5-4, 10 → digits 3-2, 11 → digits 1-0, 00 → none.
  - During the blink "hidden" phase, those digits output seg=0 (an still asserted). Prefix digits never blink.
  - Blink counter runs continuously, but its phase is forced to visible whenever the shadow state is not a set state, so entry into a set state always starts visible.
- Simultaneous events: a `sign` change in the same cycle as the 7→0 wrap is captured (the shadow samples the input on that edge).
- Mid-operation reset clears everything immediately. The first latch happens at the first wrap after release.

Decomposition:
- Package `display_pkg`:
  - Tag constants TAG_NOW=0x00, TAG_WORK=0x01, TAG_SWITCH=0x02, TAG_REMIND=0x03.
  - State codes SHUTDOWN=7'b0000000, SET_* prefix 4'b1111.
  - Segment constants SEG_DASH, SEG_C, SEG_BLANK.
- One sub-module `seg7_decode`: combinational nibble → 7 segments with the '-' fallback, instantiated once on the muxed nibble.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 → DIV=10, BLANK_CYC=2, BLINK_HZ=1 → phase toggles every 500 cycles):
- Reset:
  - Stimulus: hold rst=0, drive sign=0x12345601, state=7'b1000000.
  - Response: an=0, seg=0 throughout. After release, the first frame shows a blank display until the first wrap.
- Normal frame:
  - Stimulus: sign=0x12345601, state=7'b1000000.
  - Response: digits 7..0 = 0x39,0x06,0x06,0x5B|0x80,0x4F,0x66|0x80,0x6D,0x7D. Each an bit is high for exactly 8 of 10 cycles, and no two an bits are ever high together.
- Countdown tag:
  - Stimulus: sign=0x00000060, state=7'b1011100.
  - Response: digit7=0x7D ('6'), digit6=0x3F ('0'), digits 5..0 show 00.00.00.
- Invalid BCD:
  - Stimulus: sign=0xA0000000.
  - Response: digit5 seg=0x40; other time digits 0x3F.
- Blink:
  - Stimulus: state=7'b1111010 (SET_SWI_MIN).
  - Response: digits 3-2 alternate between decoded values and seg=0 every 500 cycles; digits 5-4 and 1-0 are steady.
- Shutdown and tear-free update:
  - Stimulus: state=0, with sign changing mid-frame.
  - Response: an=0 for the whole frame. After returning to standby, the new sign appears only from the next frame start, never within a frame.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display scanner: tag codes,
// control-state codes, segment glyphs and the edited-field encoding.
package display_pkg;

  // Tag byte values carried in sign[7:0]
  localparam logic [7:0] TAG_NOW    = 8'h00;
  localparam logic [7:0] TAG_WORK   = 8'h01;
  localparam logic [7:0] TAG_SWITCH = 8'h02;
  localparam logic [7:0] TAG_REMIND = 8'h03;

  // Control-FSM state codes relevant to the display
  localparam logic [6:0] ST_SHUTDOWN = 7'b0000000;
  localparam logic [3:0] SET_PREFIX  = 4'b1111;

  // Segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Field being edited in set states, taken from state[1:0]
  typedef enum logic [1:0] {
    FIELD_NONE = 2'b00,
    FIELD_HOUR = 2'b01,
    FIELD_MIN  = 2'b10,
    FIELD_SEC  = 2'b11
  } field_e;

  // One-hot digit enable for a digit index; bit 7 is the leftmost digit
  function automatic logic [7:0] digit_onehot(input logic [2:0] idx);
    digit_onehot = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show '-'.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Nibble lookup with dash fallback for 0xA..0xF
  always_comb begin
    glyph = SEG_DASH;
    case (nibble)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Eight-digit multiplexed 7-segment scanner. The display word and control
// state are latched once per frame so a frame never mixes old and new data.
// Each digit slot starts with a short all-off gap to avoid ghosting, and the
// field under edit blinks while the control block is in a set state.
module seg_display_scanner
  import display_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLINK_HZ  = 2,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sign,
  input  logic [6:0]  state,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int SLOT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [SLOT_W-1:0]  slot_cnt;
  logic [2:0]         digit_idx;
  logic [31:0]        shadow_sign;
  logic [6:0]         shadow_state;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_hidden;

  logic        slot_end;
  logic        blink_end;
  logic        set_mode;
  logic [7:0]  tag;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic [6:0]  glyph_sel;
  logic        dp;
  logic        edit_digit;
  field_e      field;
  logic [7:0]  an_d;
  logic [7:0]  seg_d;

  assign slot_end  = (slot_cnt == SLOT_W'(DIV - 1));
  assign blink_end = (blink_cnt == BLINK_W'(HALF - 1));
  assign tag       = shadow_sign[7:0];
  assign set_mode  = (shadow_state[6:3] == SET_PREFIX);
  assign field     = field_e'(shadow_state[1:0]);

  // Slot/digit counters; shadow registers reload as the index wraps 7 -> 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt     <= '0;
      digit_idx    <= '0;
      shadow_sign  <= '0;
      shadow_state <= ST_SHUTDOWN;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
      if (digit_idx == 3'd7) begin
        shadow_sign  <= sign;
        shadow_state <= state;
      end
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Free-running blink timer; phase held visible outside set states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else begin
      blink_cnt <= blink_end ? '0 : blink_cnt + BLINK_W'(1);
      if (!set_mode) begin
        blink_hidden <= 1'b0;
      end else if (blink_end) begin
        blink_hidden <= ~blink_hidden;
      end
    end
  end

  // Select the nibble shown on the current digit
  always_comb begin
    nibble = 4'h0;
    case (digit_idx)
      3'd0: nibble = shadow_sign[11:8];
      3'd1: nibble = shadow_sign[15:12];
      3'd2: nibble = shadow_sign[19:16];
      3'd3: nibble = shadow_sign[23:20];
      3'd4: nibble = shadow_sign[27:24];
      3'd5: nibble = shadow_sign[31:28];
      3'd6: nibble = tag[3:0];
      3'd7: nibble = tag[7:4];
      default: nibble = 4'h0;
    endcase
  end

  seg7_decode u_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Prefix override, separators, blink masking and slot blanking
  always_comb begin
    glyph_sel  = glyph;
    edit_digit = 1'b0;
    an_d       = '0;
    seg_d      = '0;
    dp         = (digit_idx == 3'd4) || (digit_idx == 3'd2);

    if (digit_idx == 3'd7) begin
      if (tag == TAG_NOW) begin
        glyph_sel = SEG_BLANK;
      end else if (tag <= TAG_REMIND) begin
        glyph_sel = SEG_C;
      end
    end else if (digit_idx == 3'd6) begin
      if (tag == TAG_NOW) begin
        glyph_sel = SEG_BLANK;
      end
    end

    case (field)
      FIELD_HOUR: edit_digit = (digit_idx == 3'd5) || (digit_idx == 3'd4);
      FIELD_MIN:  edit_digit = (digit_idx == 3'd3) || (digit_idx == 3'd2);
      FIELD_SEC:  edit_digit = (digit_idx == 3'd1) || (digit_idx == 3'd0);
      default:    edit_digit = 1'b0;
    endcase

    if ((slot_cnt >= SLOT_W'(BLANK_CYC)) && (shadow_state != ST_SHUTDOWN)) begin
      an_d = digit_onehot(digit_idx);
      if (!(set_mode && blink_hidden && edit_digit)) begin
        seg_d = {dp, glyph_sel};
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '0;
      seg <= '0;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: a per-cycle reference model
// built from frame/slot arithmetic, a table of hand-decoded frames, directed
// corner sequences (reset, shutdown, tear-free update, blink) and random data.
module tb_seg_display_scanner;

  localparam int CLK_HZ    = 1000;
  localparam int SCAN_HZ   = 100;
  localparam int BLINK_HZ  = 1;
  localparam int BLANK_CYC = 2;
  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int FRAME     = 8 * DIV;
  localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);

  // ---------------- clock / reset / DUT ----------------
  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] sign  = '0;
  logic [6:0]  state = '0;
  logic [7:0]  an;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  seg_display_scanner #(
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .BLINK_HZ  (BLINK_HZ),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sign  (sign),
    .state (state),
    .an    (an),
    .seg   (seg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] digit_glyph [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                   8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  function automatic logic [7:0] glyph_of(input logic [3:0] v);
    return (v <= 4'd9) ? digit_glyph[v] : 8'h40;
  endfunction

  // Expected {an, seg} for absolute cycle c of the scan, given the frame's data
  function automatic logic [15:0] ref_out(input int c, input logic [31:0] sh_sign,
                                          input logic [6:0] sh_state, input logic hidden);
    int slot;
    int d;
    int field;
    logic [7:0] tag;
    logic [7:0] s;
    logic [7:0] a;
    slot = c % DIV;
    d    = (c / DIV) % 8;
    tag  = sh_sign[7:0];
    if (slot < BLANK_CYC || sh_state == 7'd0) return 16'h0000;
    if (d <= 5) s = glyph_of(4'(sh_sign >> (8 + 4 * d))) | ((d == 4 || d == 2) ? 8'h80 : 8'h00);
    else if (tag == 8'h00) s = 8'h00;
    else if (d == 6) s = glyph_of(tag[3:0]);
    else s = (tag < 8'h04) ? 8'h39 : glyph_of(tag[7:4]);
    field = int'(sh_state[1:0]);
    if (sh_state[6:3] == 4'hF && hidden && field != 0 && d < 6 && d / 2 == 3 - field) s = 8'h00;
    a = 8'(1 << d);
    return {a, s};
  endfunction

  int          m_n;
  logic [31:0] m_sh_sign;
  logic [6:0]  m_sh_state;
  logic        m_hidden;
  logic [15:0] m_exp;
  logic        m_seg_care;

  // Advance the model once per clock: output of this edge comes from the
  // previous cycle's frame data, then blink phase and frame latch update.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n        = 0;
      m_sh_sign  = '0;
      m_sh_state = '0;
      m_hidden   = 1'b0;
      m_exp      = '0;
      m_seg_care = 1'b1;
    end else begin
      m_exp      = ref_out(m_n, m_sh_sign, m_sh_state, m_hidden);
      m_seg_care = (m_sh_state != 7'd0) || (m_n % DIV < BLANK_CYC);
      if (m_sh_state[6:3] != 4'hF) m_hidden = 1'b0;
      else if (m_n % HALF == HALF - 1) m_hidden = ~m_hidden;
      if (m_n % FRAME == FRAME - 1) begin
        m_sh_sign  = sign;
        m_sh_state = state;
      end
      m_n++;
    end
  end

  bit chk_en = 1'b0;

  // Every cycle: pins must match the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("an_stream", 32'(an), 32'(m_exp[15:8]));
      if (m_seg_care) check("seg_stream", 32'(seg), 32'(m_exp[7:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_now(input logic [31:0] s, input logic [6:0] st);
    #2;
    sign  = s;
    state = st;
  endtask

  task automatic drive(input logic [31:0] s, input logic [6:0] st);
    @(negedge clk);
    drive_now(s, st);
  endtask

  // Stop at the negedge where the next clock edge processes frame cycle pos
  task automatic align_to(input int pos);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(negedge clk);
      if (m_n % FRAME == pos) found = 1'b1;
    end
    if (!found) check("align_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] cap_seg [8];
  int         cap_cnt [8];
  int         overlap;

  // Observe 80 consecutive cycles and record per-digit segments and on-time
  task automatic scan_frame();
    for (int d = 0; d < 8; d++) begin
      cap_seg[d] = '0;
      cap_cnt[d] = 0;
    end
    overlap = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (!$onehot0(an)) overlap++;
      for (int d = 0; d < 8; d++) begin
        if (an[d]) begin
          cap_cnt[d]++;
          cap_seg[d] = seg;
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [31:0] sign;
    logic [6:0]  state;
    logic [63:0] exp;     // digit 7 .. digit 0, 8 bits each
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  // ---------------- test sequence ----------------
  initial begin
    int on_cnt;
    int old_seen;
    int bad;
    int hid3;
    int vis3;
    int hid5;
    int hid7;
    logic [31:0] rs;
    logic [6:0]  rst_state;
    logic [3:0]  nib;
    int pick;

    vecs[0] = '{32'h12345601, 7'b1000000, 64'h39_06_06_DB_4F_E6_6D_7D};
    vecs[1] = '{32'h00000060, 7'b1011100, 64'h7D_3F_3F_BF_3F_BF_3F_3F};
    vecs[2] = '{32'hA0000000, 7'b1000000, 64'h00_00_40_BF_3F_BF_3F_3F};
    vecs[3] = '{32'h98765402, 7'b1000001, 64'h39_5B_6F_FF_07_FD_6D_66};
    vecs[4] = '{32'h235959FF, 7'b1000000, 64'h40_40_5B_CF_6D_EF_6D_6F};
    vecs[5] = '{32'h0BCDEF45, 7'b1000000, 64'h66_6D_3F_C0_40_C0_40_40};
    vecs[6] = '{32'h11111103, 7'b1000000, 64'h39_4F_06_86_06_86_06_06};

    // Reset held with live inputs
    #1;
    rst    = 1'b0;
    sign   = 32'h12345601;
    state  = 7'b1000000;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    check("reset_an", 32'(an), 32'h0);
    check("reset_seg", 32'(seg), 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;

    // First frame after release: shadow still cleared, display dark
    on_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an != 8'h00) on_cnt++;
    end
    check("first_frame_dark", 32'(on_cnt), 32'd0);

    // Table-driven frames
    for (int v = 0; v < NVEC; v++) begin
      drive(vecs[v].sign, vecs[v].state);
      repeat (2 * FRAME) @(negedge clk);
      scan_frame();
      for (int d = 0; d < 8; d++) begin
        check($sformatf("vec%0d_digit%0d_seg", v, d), 32'(cap_seg[d]), 32'(vecs[v].exp[8 * d +: 8]));
        check($sformatf("vec%0d_digit%0d_on_cycles", v, d), 32'(cap_cnt[d]), 32'd8);
      end
      check($sformatf("vec%0d_an_overlap", v), 32'(overlap), 32'd0);
    end

    // Shutdown: no digit ever enabled, even as the data changes
    drive(32'h12345601, 7'b0000000);
    repeat (2 * FRAME) @(negedge clk);
    scan_frame();
    on_cnt = 0;
    for (int d = 0; d < 8; d++) on_cnt += cap_cnt[d];
    check("shutdown_an_cycles", 32'(on_cnt), 32'd0);
    align_to(40);
    drive_now(32'h99999901, 7'b0000000);
    scan_frame();
    on_cnt = 0;
    for (int d = 0; d < 8; d++) on_cnt += cap_cnt[d];
    check("shutdown_change_an_cycles", 32'(on_cnt), 32'd0);

    // Tear-free update: change hours mid-frame, old value must finish the frame
    drive(32'h12345601, 7'b1000000);
    repeat (2 * FRAME) @(negedge clk);
    align_to(40);
    drive_now(32'h92345601, 7'b1000000);
    old_seen = 0;
    bad      = 0;
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      if (an[5]) begin
        old_seen++;
        if (seg != 8'h06) bad++;
      end
    end
    check("tear_free_old_cycles", 32'(old_seen), 32'd8);
    check("tear_free_new_in_old_frame", 32'(bad), 32'd0);
    scan_frame();
    check("tear_free_new_digit5", 32'(cap_seg[5]), 32'h6F);

    // Change landing on the wrap edge is captured by that frame
    align_to(FRAME - 1);
    drive_now(32'h92345801, 7'b1000000);
    scan_frame();
    check("wrap_edge_capture_digit0", 32'(cap_seg[0]), 32'h7F);

    // Blink on the minutes field
    drive(32'h12345601, 7'b1111010);
    hid3 = 0;
    vis3 = 0;
    hid5 = 0;
    hid7 = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (an[3]) begin
        if (seg == 8'h00) hid3++;
        else vis3++;
      end
      if (an[5] && seg == 8'h00) hid5++;
      if (an[7] && seg == 8'h00) hid7++;
    end
    check("blink_digit3_hidden_seen", 32'(hid3 > 0), 32'd1);
    check("blink_digit3_visible_seen", 32'(vis3 > 0), 32'd1);
    check("blink_digit5_steady", 32'(hid5), 32'd0);
    check("blink_prefix_steady", 32'(hid7), 32'd0);

    // Mid-operation reset clears the pins immediately
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midreset_an", 32'(an), 32'h0);
    check("midreset_seg", 32'(seg), 32'h0);
    repeat (3) @(negedge clk);
    drive(32'h12345601, 7'b1000000);
    rst = 1'b1;
    on_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an != 8'h00) on_cnt++;
    end
    check("post_reset_first_frame_dark", 32'(on_cnt), 32'd0);

    // Randomised data and states against the model
    for (int r = 0; r < 40; r++) begin
      rs = '0;
      for (int k = 2; k < 8; k++) begin
        nib = 4'($urandom_range(0, 11));
        rs[4 * k +: 4] = nib;
      end
      pick = $urandom_range(0, 3);
      if (pick == 0) rs[7:0] = 8'h00;
      else if (pick == 1) rs[7:0] = 8'($urandom_range(1, 3));
      else rs[7:0] = 8'($urandom_range(0, 255));
      pick = $urandom_range(0, 4);
      if (pick == 0) rst_state = 7'b0000000;
      else if (pick == 1) rst_state = 7'b1000000;
      else if (pick == 2) rst_state = {4'b1111, 3'($urandom_range(0, 7))};
      else rst_state = 7'($urandom_range(0, 127));
      drive(rs, rst_state);
      repeat ($urandom_range(5, 200)) @(negedge clk);
    end

    repeat (FRAME) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
